cache_control: RTL and testbench
================================

# cache_control

Sequencing FSM for the 2-way set-associative, write-back, write-allocate L1 cache sitting between the LC-3b CPU and physical memory. It consumes tag-match/valid/dirty/LRU status from `cache_datapath` and drives that datapath's mux selects and array write enables. It also handles the CPU `mem_resp` handshake and the 128-bit `pmem` read/write handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_read`, `mem_write` in 1: CPU request. Held stable by the CPU until `mem_resp`.
- `mem_byte_enable` in 2: CPU write byte mask.
- `mem_resp` out 1: single-cycle completion pulse to the CPU.
- `tag_match0`, `tag_match1` in 1: per-way tag compare.
- `valid0_out`, `valid1_out`, `dirty0_out`, `dirty1_out` in 1: per-way status at the current index.
- `lru_out` in 1: way to evict next.
- `pmem_resp` in 1: physical memory done.
- `pmem_read`, `pmem_write` out 1: physical memory request.
- `pmem_addr_sel` out 1: address source. 0 = CPU tag+index; 1 = victim tag+index.
- `datawaymux_sel` out 1: way driving the read/writeback data.
- `datainmux_sel` out 1: data-array write source. 0 = `pmem_rdata`; 1 = CPU-merged block.
- `membytemux_sel` out 2: byte-lane select for the merge.
- `dataarr0_write`, `dataarr1_write`, `tag0_write`, `tag1_write`, `valid0_write`, `valid1_write`, `dirty0_write`, `dirty1_write` out 1: array write enables.
- `dirty_in` out 1: value written to the dirty array.
- `lru_write`, `lru_in` out 1: LRU update.

## Operation
- States: IDLE, CHECK, WRITEBACK, FILL. All outputs are decoded from state plus inputs.
- Default outputs in every state are 0, except `datawaymux_sel`, which defaults to the hit way (way0 if `tag_match0 & valid0_out`, else 1).
- hit0 = `valid0_out & tag_match0`; hit1 = `valid1_out & tag_match1`. If both are set, way0 wins.
- IDLE: `mem_read | mem_write` → CHECK. Otherwise stay in IDLE.
- CHECK, no request: → IDLE. No writes, no `mem_resp`.
- CHECK, hit on way w:
  - `mem_resp`=1, `lru_write`=1, `lru_in`=~w.
  - If `mem_write` (write takes priority when both request lines are set) and `mem_byte_enable`≠0:
    - `datainmux_sel`=1, `membytemux_sel`=`mem_byte_enable`.
    - `dataarr`w`_write`=1, `dirty`w`_write`=1, `dirty_in`=1.
  - If `mem_byte_enable`=0: respond with no data or dirty write.
  - → IDLE.
- CHECK, miss:
  - Victim selection: v = 0 if !`valid0_out`; else 1 if !`valid1_out`; else `lru_out`. v is latched into the internal `victim` register.
  - Victim valid and dirty → WRITEBACK. Otherwise → FILL.
- WRITEBACK:
  - `pmem_write`=1, `pmem_addr_sel`=1, `datawaymux_sel`=`victim`.
  - Stay until `pmem_resp`, then → FILL.
- FILL:
  - `pmem_read`=1, `pmem_addr_sel`=0.
  - On `pmem_resp`:
    - `datainmux_sel`=0.
    - `dataarr`v`_write`, `tag`v`_write`, `valid`v`_write`, `dirty`v`_write` all =1, with `dirty_in`=0.
    - → CHECK. The re-check hits and completes the access, merging write data if applicable.
- CPU request dropping during WRITEBACK or FILL: the pmem transaction still completes, then CHECK sees no request → IDLE.
- This block never clears the arrays. Valid-array initialisation belongs to the datapath.

## Timing
- Reset: asynchronous assert forces IDLE and `victim`=0. All outputs read 0 while `reset_n`=0, including `pmem_read` and `pmem_write`, which drop immediately even mid-transaction. Release is synchronous to `clk`.
- Hit latency: request seen in IDLE at cycle 0; `mem_resp` in cycle 1 (CHECK); IDLE in cycle 2.
- Clean-miss latency: 1 (IDLE) + 1 (CHECK) + N (FILL, where N includes the `pmem_resp` cycle) + 1 (CHECK, `mem_resp`).
- Dirty miss adds M WRITEBACK cycles.
- `pmem_read` and `pmem_write` are never asserted in the same cycle. Each stays high continuously until the cycle in which `pmem_resp`=1.
- Array writes take effect on the rising edge ending the cycle in which their enables are high.
- `mem_resp` is high for exactly one cycle per request. Back-to-back requests cost at least 2 cycles each.

## Test plan
- Read hit: way1 valid, tag match, `mem_read`=1 → `mem_resp` in cycle 1; `lru_write`=1, `lru_in`=0; no `pmem_*` activity.
- Write hit on way0 with `mem_byte_enable`=2'b10 → in CHECK: `membytemux_sel`=2'b10, `datainmux_sel`=1, `dataarr0_write`=1, `dirty0_write`=1, `dirty_in`=1, `lru_in`=1.
- Clean miss: both ways valid and clean, `lru_out`=1, `pmem_resp` after 3 cycles.
  - → `pmem_read`=1 for 3 cycles.
  - In the `pmem_resp` cycle: way1 data, tag, valid and dirty writes with `dirty_in`=0.
  - Next cycle: CHECK hits and `mem_resp`=1.
- Dirty miss: victim way0 dirty.
  - → `pmem_write`=1 with `pmem_addr_sel`=1 and `datawaymux_sel`=0 until `pmem_resp`.
  - Then `pmem_read`=1 with `pmem_addr_sel`=0; never both request lines high together.
- Invalid-way preference: `valid0_out`=0, `valid1_out`=1, `lru_out`=1, miss → fill targets way0 with no WRITEBACK.
- Reset mid-FILL: `reset_n`=0 while `pmem_read`=1 → `pmem_read`=0 combinationally, state returns to IDLE, no array writes, `mem_resp` stays 0.

Source files
------------

// File: rtl/cache_control.sv
// Sequencing FSM for a 2-way set-associative, write-back, write-allocate L1 cache.
// Decodes datapath selects and array write enables from the state and the tag/valid/dirty/LRU status.
module cache_control (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       mem_read_i,
  input  logic       mem_write_i,
  input  logic [1:0] mem_byte_enable_i,
  output logic       mem_resp_o,
  input  logic       tag_match0_i,
  input  logic       tag_match1_i,
  input  logic       valid0_out_i,
  input  logic       valid1_out_i,
  input  logic       dirty0_out_i,
  input  logic       dirty1_out_i,
  input  logic       lru_out_i,
  input  logic       pmem_resp_i,
  output logic       pmem_read_o,
  output logic       pmem_write_o,
  output logic       pmem_addr_sel_o,
  output logic       datawaymux_sel_o,
  output logic       datainmux_sel_o,
  output logic [1:0] membytemux_sel_o,
  output logic       dataarr0_write_o,
  output logic       dataarr1_write_o,
  output logic       tag0_write_o,
  output logic       tag1_write_o,
  output logic       valid0_write_o,
  output logic       valid1_write_o,
  output logic       dirty0_write_o,
  output logic       dirty1_write_o,
  output logic       dirty_in_o,
  output logic       lru_write_o,
  output logic       lru_in_o
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;

  logic req, hit0, hit1, hit_way, miss_victim, victim_needs_wb;

  assign req     = mem_read_i | mem_write_i;
  assign hit0    = valid0_out_i & tag_match0_i;
  assign hit1    = valid1_out_i & tag_match1_i;
  assign hit_way = ~hit0;

  // Empty ways are filled before anything is evicted; way0 is preferred.
  assign miss_victim     = !valid0_out_i ? 1'b0 : (!valid1_out_i ? 1'b1 : lru_out_i);
  assign victim_needs_wb = miss_victim ? (valid1_out_i & dirty1_out_i)
                                       : (valid0_out_i & dirty0_out_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    victim_d         = victim_q;
    mem_resp_o       = 1'b0;
    pmem_read_o      = 1'b0;
    pmem_write_o     = 1'b0;
    pmem_addr_sel_o  = 1'b0;
    datawaymux_sel_o = hit_way;
    datainmux_sel_o  = 1'b0;
    membytemux_sel_o = 2'b00;
    dataarr0_write_o = 1'b0;
    dataarr1_write_o = 1'b0;
    tag0_write_o     = 1'b0;
    tag1_write_o     = 1'b0;
    valid0_write_o   = 1'b0;
    valid1_write_o   = 1'b0;
    dirty0_write_o   = 1'b0;
    dirty1_write_o   = 1'b0;
    dirty_in_o       = 1'b0;
    lru_write_o      = 1'b0;
    lru_in_o         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) state_d = CHECK;
      end
      CHECK: begin
        if (!req) begin
          state_d = IDLE;
        end else if (hit0 | hit1) begin
          mem_resp_o  = 1'b1;
          lru_write_o = 1'b1;
          lru_in_o    = ~hit_way;
          // A write with an empty byte mask completes without touching data or dirty bits.
          if (mem_write_i && (mem_byte_enable_i != 2'b00)) begin
            datainmux_sel_o  = 1'b1;
            membytemux_sel_o = mem_byte_enable_i;
            dataarr0_write_o = ~hit_way;
            dataarr1_write_o = hit_way;
            dirty0_write_o   = ~hit_way;
            dirty1_write_o   = hit_way;
            dirty_in_o       = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d = miss_victim;
          state_d  = victim_needs_wb ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write_o     = 1'b1;
        pmem_addr_sel_o  = 1'b1;
        datawaymux_sel_o = victim_q;
        if (pmem_resp_i) state_d = FILL;
      end
      FILL: begin
        pmem_read_o = 1'b1;
        if (pmem_resp_i) begin
          dataarr0_write_o = ~victim_q;
          dataarr1_write_o = victim_q;
          tag0_write_o     = ~victim_q;
          tag1_write_o     = victim_q;
          valid0_write_o   = ~victim_q;
          valid1_write_o   = victim_q;
          dirty0_write_o   = ~victim_q;
          dirty1_write_o   = victim_q;
          state_d          = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are forced low for the whole reset window so an in-flight pmem request drops at once.
    if (!reset_n_i) begin
      mem_resp_o       = 1'b0;
      pmem_read_o      = 1'b0;
      pmem_write_o     = 1'b0;
      pmem_addr_sel_o  = 1'b0;
      datawaymux_sel_o = 1'b0;
      datainmux_sel_o  = 1'b0;
      membytemux_sel_o = 2'b00;
      dataarr0_write_o = 1'b0;
      dataarr1_write_o = 1'b0;
      tag0_write_o     = 1'b0;
      tag1_write_o     = 1'b0;
      valid0_write_o   = 1'b0;
      valid1_write_o   = 1'b0;
      dirty0_write_o   = 1'b0;
      dirty1_write_o   = 1'b0;
      dirty_in_o       = 1'b0;
      lru_write_o      = 1'b0;
      lru_in_o         = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: a behavioural datapath/memory environment driven by the DUT,
// compared against a transaction-level 2-way cache model.
module tb_cache_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0;
  logic [1:0]  memByteEnable = 2'b00;
  logic [2:0]  reqTag = 3'd0;
  logic [1:0]  reqIdx = 2'd0;
  logic [15:0] wdata = 16'h0000;
  logic        memResp, tagMatch0, tagMatch1, valid0Out, valid1Out, dirty0Out, dirty1Out, lruOut;
  logic        pmemResp = 1'b0;
  logic        pmemRead, pmemWrite, pmemAddrSel, datawaymuxSel, datainmuxSel;
  logic [1:0]  membytemuxSel;
  logic        dataarr0Write, dataarr1Write, tag0Write, tag1Write, valid0Write, valid1Write;
  logic        dirty0Write, dirty1Write, dirtyIn, lruWrite, lruIn;

  cache_control dut (
    .clk_i(clk), .reset_n_i(resetN),
    .mem_read_i(memRead), .mem_write_i(memWrite), .mem_byte_enable_i(memByteEnable),
    .mem_resp_o(memResp),
    .tag_match0_i(tagMatch0), .tag_match1_i(tagMatch1),
    .valid0_out_i(valid0Out), .valid1_out_i(valid1Out),
    .dirty0_out_i(dirty0Out), .dirty1_out_i(dirty1Out), .lru_out_i(lruOut),
    .pmem_resp_i(pmemResp), .pmem_read_o(pmemRead), .pmem_write_o(pmemWrite),
    .pmem_addr_sel_o(pmemAddrSel), .datawaymux_sel_o(datawaymuxSel),
    .datainmux_sel_o(datainmuxSel), .membytemux_sel_o(membytemuxSel),
    .dataarr0_write_o(dataarr0Write), .dataarr1_write_o(dataarr1Write),
    .tag0_write_o(tag0Write), .tag1_write_o(tag1Write),
    .valid0_write_o(valid0Write), .valid1_write_o(valid1Write),
    .dirty0_write_o(dirty0Write), .dirty1_write_o(dirty1Write),
    .dirty_in_o(dirtyIn), .lru_write_o(lruWrite), .lru_in_o(lruIn)
  );

  // Field order: resp, pread, pwrite, addrsel, waysel, insel, bytesel[1:0], da0 da1 t0 t1 v0 v1 d0 d1, din, lruw, lruin
  logic [18:0] outVec;
  assign outVec = {memResp, pmemRead, pmemWrite, pmemAddrSel, datawaymuxSel, datainmuxSel,
                   membytemuxSel, dataarr0Write, dataarr1Write, tag0Write, tag1Write,
                   valid0Write, valid1Write, dirty0Write, dirty1Write, dirtyIn, lruWrite, lruIn};

  function automatic logic [15:0] mergeLine(input logic [15:0] old, input logic [15:0] wd,
                                            input logic [1:0] mask);
    mergeLine[7:0]  = mask[0] ? wd[7:0]  : old[7:0];
    mergeLine[15:8] = mask[1] ? wd[15:8] : old[15:8];
  endfunction

  // Environment: arrays and memory that react to the DUT's enables like the real datapath would.
  logic [2:0]  eTag  [2][4];
  logic        eValid[2][4];
  logic        eDirty[2][4];
  logic [15:0] eData [2][4];
  logic        eLru  [4];
  logic [15:0] memArr[32];
  logic [4:0]  pAddr;

  assign tagMatch0 = (eTag[0][reqIdx] == reqTag);
  assign tagMatch1 = (eTag[1][reqIdx] == reqTag);
  assign valid0Out = eValid[0][reqIdx];
  assign valid1Out = eValid[1][reqIdx];
  assign dirty0Out = eDirty[0][reqIdx];
  assign dirty1Out = eDirty[1][reqIdx];
  assign lruOut    = eLru[reqIdx];
  assign pAddr     = pmemAddrSel ? {eTag[datawaymuxSel][reqIdx], reqIdx} : {reqTag, reqIdx};

  logic        doInit = 1'b0, doPreload = 1'b0;
  logic [1:0]  preIdx;
  logic        preV0, preV1, preD0, preD1, preLru;
  logic [2:0]  preT0, preT1;
  logic [15:0] preData0, preData1;

  always @(posedge clk) begin
    if (doInit) begin
      for (int i = 0; i < 32; i++) memArr[i] <= 16'(i * 291 + 17767);
      for (int i = 0; i < 4; i++) begin
        eLru[i] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          eTag[w][i] <= 3'd0; eValid[w][i] <= 1'b0; eDirty[w][i] <= 1'b0; eData[w][i] <= 16'h0;
        end
      end
    end else if (doPreload) begin
      eValid[0][preIdx] <= preV0;  eValid[1][preIdx] <= preV1;
      eDirty[0][preIdx] <= preD0;  eDirty[1][preIdx] <= preD1;
      eTag[0][preIdx]   <= preT0;  eTag[1][preIdx]   <= preT1;
      eData[0][preIdx]  <= preData0; eData[1][preIdx] <= preData1;
      eLru[preIdx]      <= preLru;
    end else begin
      if (dataarr0Write)
        eData[0][reqIdx] <= datainmuxSel ? mergeLine(eData[0][reqIdx], wdata, membytemuxSel) : memArr[pAddr];
      if (dataarr1Write)
        eData[1][reqIdx] <= datainmuxSel ? mergeLine(eData[1][reqIdx], wdata, membytemuxSel) : memArr[pAddr];
      if (tag0Write)   eTag[0][reqIdx]   <= reqTag;
      if (tag1Write)   eTag[1][reqIdx]   <= reqTag;
      if (valid0Write) eValid[0][reqIdx] <= 1'b1;
      if (valid1Write) eValid[1][reqIdx] <= 1'b1;
      if (dirty0Write) eDirty[0][reqIdx] <= dirtyIn;
      if (dirty1Write) eDirty[1][reqIdx] <= dirtyIn;
      if (lruWrite)    eLru[reqIdx]      <= lruIn;
      if (pmemWrite && pmemResp) memArr[pAddr] <= eData[datawaymuxSel][reqIdx];
    end
  end

  // Physical memory responder: answers after wbLat/fillLat cycles of a continuous request.
  int wbLat = 1, fillLat = 1, pCnt = 0, curLat = 1;
  always begin
    @(posedge clk);
    #2;
    if (pmemRead || pmemWrite) begin
      curLat = pmemWrite ? wbLat : fillLat;
      if (pCnt >= curLat - 1) begin pmemResp = 1'b1; pCnt = 0; end
      else begin pmemResp = 1'b0; pCnt++; end
    end else begin
      pmemResp = 1'b0;
      pCnt = 0;
    end
  end

  int respCount = 0, wbCount = 0, fillCount = 0, bothCount = 0;
  always @(negedge clk) begin
    if (memResp) respCount++;
    if (pmemWrite && pmemResp) wbCount++;
    if (pmemRead && pmemResp) fillCount++;
    if (pmemRead && pmemWrite) bothCount++;
  end

  // Reference model: a 2-way cache with LRU replacement and a backing memory.
  logic [2:0]  mTag  [2][4];
  logic        mValid[2][4];
  logic        mDirty[2][4];
  logic [15:0] mData [2][4];
  logic        mLru  [4];
  logic [15:0] mMem  [32];

  task automatic modelInit();
    for (int i = 0; i < 32; i++) mMem[i] = 16'(i * 291 + 17767);
    for (int i = 0; i < 4; i++) begin
      mLru[i] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mTag[w][i] = 3'd0; mValid[w][i] = 1'b0; mDirty[w][i] = 1'b0; mData[w][i] = 16'h0;
      end
    end
  endtask

  task automatic modelAccess(input logic isW, input logic [1:0] be, input logic [15:0] wd,
                             input logic [2:0] tag, input logic [1:0] idx, input int wbL, input int fillL,
                             output int expCyc, output logic [15:0] expRd, output int expWb, output int expFill);
    int w;
    expCyc = 1; expWb = 0; expFill = 0;
    if (mValid[0][idx] && mTag[0][idx] == tag)      w = 0;
    else if (mValid[1][idx] && mTag[1][idx] == tag) w = 1;
    else begin
      w = !mValid[0][idx] ? 0 : (!mValid[1][idx] ? 1 : int'(mLru[idx]));
      if (mValid[w][idx] && mDirty[w][idx]) begin
        mMem[{mTag[w][idx], idx}] = mData[w][idx];
        expWb = 1;
        expCyc += wbL;
      end
      mData[w][idx] = mMem[{tag, idx}];
      mTag[w][idx] = tag; mValid[w][idx] = 1'b1; mDirty[w][idx] = 1'b0;
      expFill = 1;
      expCyc += 1 + fillL;
    end
    expRd = mData[w][idx];
    mLru[idx] = (w == 0);
    if (isW && be != 2'b00) begin
      mData[w][idx] = mergeLine(mData[w][idx], wd, be);
      mDirty[w][idx] = 1'b1;
    end
  endtask

  function automatic logic [42:0] envSet(input logic [1:0] idx);
    return {eValid[0][idx], eValid[1][idx], eDirty[0][idx], eDirty[1][idx], eLru[idx],
            eTag[0][idx], eTag[1][idx], eData[0][idx], eData[1][idx]};
  endfunction

  function automatic logic [42:0] modelSet(input logic [1:0] idx);
    return {mValid[0][idx], mValid[1][idx], mDirty[0][idx], mDirty[1][idx], mLru[idx],
            mTag[0][idx], mTag[1][idx], mData[0][idx], mData[1][idx]};
  endfunction

  int testsRun = 0, testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  task automatic preloadSet(input logic [1:0] idx, input logic v0, input logic v1, input logic d0,
                            input logic d1, input logic lru, input logic [2:0] t0, input logic [2:0] t1,
                            input logic [15:0] data0, input logic [15:0] data1);
    preIdx = idx; preV0 = v0; preV1 = v1; preD0 = d0; preD1 = d1; preLru = lru;
    preT0 = t0; preT1 = t1; preData0 = data0; preData1 = data1;
    mValid[0][idx] = v0; mValid[1][idx] = v1; mDirty[0][idx] = d0; mDirty[1][idx] = d1;
    mTag[0][idx] = t0; mTag[1][idx] = t1; mData[0][idx] = data0; mData[1][idx] = data1;
    mLru[idx] = lru;
    doPreload = 1'b1;
    @(posedge clk);
    #1 doPreload = 1'b0;
  endtask

  logic [18:0] cycLog[64];

  task automatic applyStimulus(input logic isW, input logic rdAlso, input logic [1:0] be,
                               input logic [15:0] wd, input logic [2:0] tag, input logic [1:0] idx,
                               input int wbL, input int fillL);
    int expCyc, expWb, expFill, respCyc, rc0, wb0, fc0, bc0;
    logic [15:0] expRd, rdObs;
    modelAccess(isW, be, wd, tag, idx, wbL, fillL, expCyc, expRd, expWb, expFill);
    @(posedge clk);
    #1;
    rc0 = respCount; wb0 = wbCount; fc0 = fillCount; bc0 = bothCount;
    wbLat = wbL; fillLat = fillL;
    reqTag = tag; reqIdx = idx; wdata = wd; memByteEnable = be;
    memWrite = isW; memRead = isW ? rdAlso : 1'b1;
    respCyc = -1;
    rdObs = 16'h0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      cycLog[cyc] = outVec;
      if (memResp) begin
        respCyc = cyc;
        rdObs = eData[datawaymuxSel][reqIdx];
        break;
      end
    end
    @(posedge clk);
    #1;
    memRead = 1'b0; memWrite = 1'b0;
    checkOutput("respCycle", 64'(respCyc), 64'(expCyc));
    checkOutput("respPulses", 64'(respCount - rc0), 64'd1);
    if (!isW) checkOutput("readData", 64'(rdObs), 64'(expRd));
    checkOutput("writebacks", 64'(wbCount - wb0), 64'(expWb));
    checkOutput("fills", 64'(fillCount - fc0), 64'(expFill));
    checkOutput("pmemBothHigh", 64'(bothCount - bc0), 64'd0);
    checkOutput("setState", 64'(envSet(idx)), 64'(modelSet(idx)));
  endtask

  initial begin
    int rc0;
    // Reset: every output low even with a request pending.
    resetN = 1'b0;
    doInit = 1'b1;
    @(posedge clk);
    #1 doInit = 1'b0;
    memRead = 1'b1; memWrite = 1'b1; memByteEnable = 2'b11;
    @(negedge clk);
    checkOutput("resetOutputs", 64'(outVec), 64'd0);
    memRead = 1'b0; memWrite = 1'b0;
    @(posedge clk);
    #1 resetN = 1'b1;
    modelInit();

    // Reset asserted in the middle of a fill.
    rc0 = respCount;
    fillLat = 10; reqTag = 3'd1; reqIdx = 2'd0; memRead = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("fillStarted", 64'(pmemRead), 64'd1);
    #1 resetN = 1'b0;
    memRead = 1'b0;
    #1;
    checkOutput("rstPmemRead", 64'(pmemRead), 64'd0);
    checkOutput("rstOutputs", 64'(outVec), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
    checkOutput("rstNoResp", 64'(respCount - rc0), 64'd0);
    checkOutput("rstSetState", 64'(envSet(2'd0)), 64'(modelSet(2'd0)));
    applyStimulus(1'b0, 1'b0, 2'b00, 16'h0, 3'd1, 2'd0, 1, 2);

    // Read hit on way1.
    preloadSet(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 16'h0000, 16'h1111);
    applyStimulus(1'b0, 1'b0, 2'b00, 16'h0, 3'd3, 2'd0, 1, 1);
    checkOutput("readHitVec", 64'(cycLog[1]), 64'(19'b1_000_1_0_00_00000000_0_1_0));

    // Write hit on way0, upper byte only, with both request lines set.
    preloadSet(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd3, 16'h7777, 16'h1111);
    applyStimulus(1'b1, 1'b1, 2'b10, 16'hBEEF, 3'd2, 2'd0, 1, 1);
    checkOutput("writeHitVec", 64'(cycLog[1]), 64'(19'b1_000_0_1_10_10000010_1_1_1));

    // Clean miss, LRU evicts way1, three-cycle fill.
    preloadSet(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 16'h2222, 16'h3333);
    applyStimulus(1'b0, 1'b0, 2'b00, 16'h0, 3'd4, 2'd1, 1, 3);
    checkOutput("cleanFillWait", 64'(cycLog[2]), 64'(19'b0_100_1_0_00_00000000_0_0_0));
    checkOutput("cleanFillDone", 64'(cycLog[4]), 64'(19'b0_100_1_0_00_01010101_0_0_0));
    checkOutput("cleanRecheck", 64'(cycLog[5]), 64'(19'b1_000_1_0_00_00000000_0_1_0));

    // Dirty miss on way0: writeback, then fill, then merged write.
    preloadSet(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd6, 16'h4444, 16'h5555);
    applyStimulus(1'b1, 1'b0, 2'b01, 16'h00AB, 3'd7, 2'd2, 2, 1);
    checkOutput("dirtyWbVec", 64'(cycLog[2]), 64'(19'b0_011_0_0_00_00000000_0_0_0));
    checkOutput("dirtyFillVec", 64'(cycLog[4]), 64'(19'b0_100_1_0_00_10101010_0_0_0));
    checkOutput("dirtyRecheck", 64'(cycLog[5]), 64'(19'b1_000_0_1_01_10000010_1_1_1));

    // Invalid way0 is filled ahead of the LRU (dirty) way1.
    preloadSet(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 16'h0000, 16'h6666);
    applyStimulus(1'b0, 1'b0, 2'b00, 16'h0, 3'd2, 2'd3, 1, 1);
    checkOutput("invalidPrefVec", 64'(cycLog[2]), 64'(19'b0_100_1_0_00_10101010_0_0_0));

    // Randomized traffic over a small tag range so hits, evictions and writebacks all occur.
    for (int n = 0; n < 250; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    16'($urandom), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
